// File: rtl/qimag_serial_add_ctrl_pkg.sv
// Shared types for the digit-serial quater-imaginary (base 2i) adder.
package qimag_pkg;

    localparam int QIMAG_GUARD_DIGITS = 4;

    typedef logic [1:0] qdigit_t;

    typedef struct packed {
        logic pos;
        logic neg;
    } qcarry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qstate_t;

endpackage

// File: rtl/qimag_serial_add_ctrl_full_add.sv
// One base-2i digit cell: carries travel two positions up and carry the opposite sign,
// because (2i)^2 = -4.
module QImagFullAdd
    import qimag_pkg::*;
(
    input  qdigit_t a,
    input  qdigit_t b,
    input  logic    c_in_neg,
    input  logic    c_in_pos,
    output qdigit_t s,
    output logic    c_out_neg,
    output logic    c_out_pos
);

    logic [3:0] t;

    // t lies in -1..7, so a 4-bit two's-complement sum is exact and t[1:0] is t mod 4
    always_comb begin
        t = {2'b00, a} + {2'b00, b} + {3'b000, c_in_pos} - {3'b000, c_in_neg};
        s = t[1:0];
        c_out_pos = (t == 4'hF);
        c_out_neg = t[2] & ~t[3];
    end

endmodule

// File: rtl/qimag_serial_add_ctrl.sv
// Digit-serial base-2i adder: one QImagFullAdd reused over all NDIGITS+4 positions,
// with a two-stage carry pipe bridging the k -> k+2 carry distance.
module qimag_serial_add_ctrl
    import qimag_pkg::*;
#(
    parameter int NDIGITS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*NDIGITS-1:0]           a,
    input  logic [2*NDIGITS-1:0]           b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*(NDIGITS+4)-1:0]       sum,
    output logic                           busy
);

    localparam int NSUM  = NDIGITS + QIMAG_GUARD_DIGITS;
    localparam int IDX_W = $clog2(NSUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSUM - 1);

    qstate_t              state;
    logic [2*NDIGITS-1:0] a_sr;
    logic [2*NDIGITS-1:0] b_sr;
    logic [IDX_W-1:0]     idx;
    qcarry_t              carry_s1;
    qcarry_t              carry_s2;
    qcarry_t              carry_new;
    qdigit_t              digit_s;
    logic [2*NSUM-1:0]    sum_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    QImagFullAdd u_cell (
        .a         (a_sr[1:0]),
        .b         (b_sr[1:0]),
        .c_in_neg  (carry_s2.neg),
        .c_in_pos  (carry_s2.pos),
        .s         (digit_s),
        .c_out_neg (carry_new.neg),
        .c_out_pos (carry_new.pos)
    );

    // Operand registers shift in zeros, so the guard digits see 0 + 0 + carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            idx         <= '0;
            carry_s1    <= '0;
            carry_s2    <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sr       <= a;
                        b_sr       <= b;
                        carry_s1   <= '0;
                        carry_s2   <= '0;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[{idx, 1'b0} +: 2] <= digit_s;
                    a_sr     <= {2'b00, a_sr[2*NDIGITS-1:2]};
                    b_sr     <= {2'b00, b_sr[2*NDIGITS-1:2]};
                    carry_s2 <= carry_s1;
                    carry_s1 <= carry_new;
                    if (idx == LAST_IDX) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_qimag_serial_add_ctrl.sv
// Directed self-checking bench for qimag_serial_add_ctrl (NDIGITS=8).
module tb_qimag_serial_add_ctrl;

    localparam int ND = 8;
    localparam int SW = 2 * (ND + 4);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2*ND-1:0] a = '0;
    logic [2*ND-1:0] b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [SW-1:0] sum;
    logic          busy;

    int errors = 0;
    int checks = 0;

    qimag_serial_add_ctrl #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Base-2i word -> Gaussian integer: even digits weigh (-4)^m, odd digits 2i*(-4)^m
    function automatic void decode(input logic [2*ND-1:0] v, output longint re, output longint im);
        longint p;
        re = 0;
        im = 0;
        for (int k = 0; k < ND; k++) begin
            p = 1;
            for (int m = 0; m < k / 2; m++) p = p * -4;
            if (k % 2 == 0) re += longint'(v[2*k +: 2]) * p;
            else            im += 2 * longint'(v[2*k +: 2]) * p;
        end
    endfunction

    function automatic logic [SW-1:0] encode(input longint re, input longint im);
        logic [SW-1:0] r;
        longint n;
        longint d;
        r = '0;
        n = re;
        for (int j = 0; j < (ND + 4) / 2; j++) begin
            d = ((n % 4) + 4) % 4;
            r[4*j +: 2] = d[1:0];
            n = (n - d) / -4;
        end
        n = im / 2;
        for (int j = 0; j < (ND + 4) / 2; j++) begin
            d = ((n % 4) + 4) % 4;
            r[4*j+2 +: 2] = d[1:0];
            n = (n - d) / -4;
        end
        return r;
    endfunction

    // Presents operands and returns just after the acceptance edge
    task automatic start_add(input logic [2*ND-1:0] av, input logic [2*ND-1:0] bv);
        int n;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
    endtask

    // Called right after the acceptance edge; lat counts that edge as 1
    task automatic wait_result(output logic [SW-1:0] res, output int lat, output int busy_cnt,
                               output int multi, output bit pipe_nz);
        lat = 1;
        busy_cnt = 0;
        multi = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            if (dut.carry_new.pos && dut.carry_new.neg) multi++;
            if (dut.carry_s2.pos && dut.carry_s2.neg) multi++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = sum;
        pipe_nz = |{dut.carry_s1, dut.carry_s2};
    endtask

    task automatic finish_add();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sum !== '0) begin errors++; $display("[TB] FAIL reset_sum got=%h exp=0", sum); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_small_add();
        logic [SW-1:0] res; int lat, bc, multi; bit pnz;
        start_add(16'h0001, 16'h0003);
        wait_result(res, lat, bc, multi, pnz);
        checks++; if (res !== 24'h000130) begin errors++; $display("[TB] FAIL add_1_3 got=%h exp=000130", res); end
        checks++; if (lat !== 13) begin errors++; $display("[TB] FAIL latency got=%0d exp=13", lat); end
        checks++; if (pnz !== 1'b0) begin errors++; $display("[TB] FAIL pipe_1_3 got=%b exp=0", pnz); end
        finish_add();
    endtask

    task automatic test_carry();
        logic [SW-1:0] res; int lat, bc, multi; bit pnz;
        start_add(16'h0003, 16'h0003);
        wait_result(res, lat, bc, multi, pnz);
        checks++; if (res !== 24'h000132) begin errors++; $display("[TB] FAIL add_3_3 got=%h exp=000132", res); end
        checks++; if (multi !== 0) begin errors++; $display("[TB] FAIL carry_onehot got=%0d exp=0", multi); end
        finish_add();
    endtask

    task automatic test_all_threes();
        logic [SW-1:0] res, exp_sum; int lat, bc, multi; bit pnz;
        longint ra, ia, rb, ib;
        decode(16'hFFFF, ra, ia);
        decode(16'hFFFF, rb, ib);
        exp_sum = encode(ra + rb, ia + ib);
        start_add(16'hFFFF, 16'hFFFF);
        wait_result(res, lat, bc, multi, pnz);
        checks++; if (res !== exp_sum) begin errors++; $display("[TB] FAIL all_threes got=%h exp=%h", res, exp_sum); end
        checks++; if (pnz !== 1'b0) begin errors++; $display("[TB] FAIL pipe_all_threes got=%b exp=0", pnz); end
        checks++; if (multi !== 0) begin errors++; $display("[TB] FAIL carry_onehot_3s got=%0d exp=0", multi); end
        finish_add();
    endtask

    task automatic test_zero_busy();
        logic [SW-1:0] res; int lat, bc, multi; bit pnz;
        start_add(16'h0000, 16'h0000);
        wait_result(res, lat, bc, multi, pnz);
        checks++; if (res !== '0) begin errors++; $display("[TB] FAIL add_zero got=%h exp=0", res); end
        checks++; if (bc !== 12) begin errors++; $display("[TB] FAIL busy_cycles got=%0d exp=12", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_done got=%b exp=0", busy); end
        finish_add();
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] res; int lat, bc, multi; bit pnz;
        start_add(16'h0003, 16'h0003);
        wait_result(res, lat, bc, multi, pnz);
        a = 16'h0002;
        b = 16'h0004;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (sum !== 24'h000132) begin errors++; $display("[TB] FAIL hold_sum[%0d] got=%h exp=000132", i, sum); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_out_valid[%0d] got=%b exp=1", i, out_valid); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        wait_result(res, lat, bc, multi, pnz);
        checks++; if (res !== 24'h000006) begin errors++; $display("[TB] FAIL pending_sum got=%h exp=000006", res); end
        checks++; if (lat !== 13) begin errors++; $display("[TB] FAIL pending_latency got=%0d exp=13", lat); end
        finish_add();
    endtask

    task automatic test_reset_mid_run();
        logic [SW-1:0] res; int lat, bc, multi; bit pnz;
        start_add(16'h0003, 16'h0003);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (sum !== 24'h000132) begin errors++; $display("[TB] FAIL partial_sum got=%h exp=000132", sum); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("[TB] FAIL abort_sum got=%h exp=0", sum); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready got=%b exp=1", in_ready); end
        start_add(16'h0002, 16'h0002);
        wait_result(res, lat, bc, multi, pnz);
        checks++; if (res !== 24'h000130) begin errors++; $display("[TB] FAIL add_2_2 got=%h exp=000130", res); end
        finish_add();
    endtask

    initial begin
        test_reset();
        test_small_add();
        test_carry();
        test_all_threes();
        test_zero_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
